// File: rtl/sram_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-port synchronous SRAM between two requesters. Port 0 is
// instruction fetch and port 1 is data access. At most one access is granted
// per cycle. An owner pipeline of RD_LATENCY stages records who issued each
// access, so that every response returns to the port that issued it.
//
// Parameters
//   RD_LATENCY : SRAM read latency in cycles (legal range 1..4)
//   ARB_MODE   : 0 = round-robin, 1 = fixed priority (port 1 wins)
//
// Ports
//   clk, resetn               clock / asynchronous active-low reset
//   pX_req, pX_wr             request, write(1)/read(0)
//   pX_wstrb, pX_addr         byte strobes, byte address
//   pX_wdata                  write data
//   pX_addr_ok                request accepted this cycle
//   pX_data_ok, pX_rdata      response valid, read data (pass-through)
//   sram_en, sram_we          SRAM enable, byte write enables
//   sram_addr, sram_wdata     SRAM address, write data
//   sram_rdata                SRAM read data, RD_LATENCY cycles after enable
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ARB_MODE   = 0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        p0_req,
    input  logic        p0_wr,
    input  logic [3:0]  p0_wstrb,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_addr_ok,
    output logic        p0_data_ok,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_wr,
    input  logic [3:0]  p1_wstrb,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_addr_ok,
    output logic        p1_data_ok,
    output logic [31:0] p1_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic {
        RR_P0 = 1'b0,
        RR_P1 = 1'b1
    } rr_ptr_t;

    rr_ptr_t                rr_q;
    logic                   gnt0;
    logic                   gnt1;
    logic                   both_req;
    logic [RD_LATENCY-1:0]  pipe_vld;
    logic [RD_LATENCY-1:0]  pipe_id;

    // Grant decision. Gated by resetn so nothing reaches the SRAM while
    // the block is held in reset.
    always_comb begin
        both_req = p0_req & p1_req;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        if (resetn) begin
            if (p1_req && (!p0_req || (ARB_MODE == 1) || (rr_q == RR_P1))) begin
                gnt1 = 1'b1;
            end else if (p0_req) begin
                gnt0 = 1'b1;
            end
        end
    end

    // Round-robin pointer only moves on contended cycles, towards the loser.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_q <= RR_P1;
        end else if (both_req) begin
            rr_q <= gnt1 ? RR_P0 : RR_P1;
        end
    end

    // SRAM side mux; port 0 payload is presented when idle (en=0 masks it).
    always_comb begin
        p0_addr_ok = gnt0;
        p1_addr_ok = gnt1;
        sram_en    = gnt0 | gnt1;
        sram_we    = '0;
        sram_addr  = p0_addr;
        sram_wdata = p0_wdata;
        if (gnt1) begin
            sram_addr  = p1_addr;
            sram_wdata = p1_wdata;
            if (p1_wr) begin
                sram_we = p1_wstrb;
            end
        end else if (gnt0 && p0_wr) begin
            sram_we = p0_wstrb;
        end
    end

    // Owner pipeline: stage 0 captures {grant, owner}, all stages shift
    // every cycle. Reset drops every in-flight response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            pipe_vld[0] <= gnt0 | gnt1;
            pipe_id[0]  <= gnt1;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    assign p0_data_ok = pipe_vld[RD_LATENCY-1] & ~pipe_id[RD_LATENCY-1];
    assign p1_data_ok = pipe_vld[RD_LATENCY-1] &  pipe_id[RD_LATENCY-1];
    assign p0_rdata   = sram_rdata;
    assign p1_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Two arbiter instances share one clock:
//   inst 0 : RD_LATENCY=1, round-robin
//   inst 1 : RD_LATENCY=3, fixed priority (port 1 wins)
// Each instance has its own SRAM model. Stimulus pushes the expected response
// (due cycle, data) into a per-port queue when a grant is expected; a monitor
// pops and compares whenever a response is due and otherwise requires
// data_ok low.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn      [2];
    logic        p0_req      [2];
    logic        p0_wr       [2];
    logic [3:0]  p0_wstrb    [2];
    logic [31:0] p0_addr     [2];
    logic [31:0] p0_wdata    [2];
    logic        p0_addr_ok  [2];
    logic        p0_data_ok  [2];
    logic [31:0] p0_rdata    [2];
    logic        p1_req      [2];
    logic        p1_wr       [2];
    logic [3:0]  p1_wstrb    [2];
    logic [31:0] p1_addr     [2];
    logic [31:0] p1_wdata    [2];
    logic        p1_addr_ok  [2];
    logic        p1_data_ok  [2];
    logic [31:0] p1_rdata    [2];
    logic        sram_en     [2];
    logic [3:0]  sram_we     [2];
    logic [31:0] sram_addr   [2];
    logic [31:0] sram_wdata  [2];
    logic [31:0] sram_rdata  [2];

    logic [31:0] ref_mem [2][64];
    exp_t        exp_q   [4][$];
    int          cyc    = 0;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int k);
        if (k == 7) return 32'hDEADBEEF;
        return 32'hA000_0000 | (k * 4);
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        localparam int unsigned MODE = (g == 0) ? 0 : 1;

        sram_port_arbiter #(.RD_LATENCY(LAT), .ARB_MODE(MODE)) dut (
            .clk        (clk),
            .resetn     (resetn[g]),
            .p0_req     (p0_req[g]),
            .p0_wr      (p0_wr[g]),
            .p0_wstrb   (p0_wstrb[g]),
            .p0_addr    (p0_addr[g]),
            .p0_wdata   (p0_wdata[g]),
            .p0_addr_ok (p0_addr_ok[g]),
            .p0_data_ok (p0_data_ok[g]),
            .p0_rdata   (p0_rdata[g]),
            .p1_req     (p1_req[g]),
            .p1_wr      (p1_wr[g]),
            .p1_wstrb   (p1_wstrb[g]),
            .p1_addr    (p1_addr[g]),
            .p1_wdata   (p1_wdata[g]),
            .p1_addr_ok (p1_addr_ok[g]),
            .p1_data_ok (p1_data_ok[g]),
            .p1_rdata   (p1_rdata[g]),
            .sram_en    (sram_en[g]),
            .sram_we    (sram_we[g]),
            .sram_addr  (sram_addr[g]),
            .sram_wdata (sram_wdata[g]),
            .sram_rdata (sram_rdata[g])
        );

        // SRAM model: read word enters a LAT-deep delay line.
        logic [31:0] mem [64];
        logic [31:0] dl  [LAT];

        initial begin
            for (int k = 0; k < 64; k++) mem[k] = init_word(k);
        end

        always @(posedge clk) begin
            if (sram_en[g]) begin
                dl[0] <= mem[sram_addr[g][7:2]];
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[g][b]) mem[sram_addr[g][7:2]][b*8 +: 8] <= sram_wdata[g][b*8 +: 8];
                end
            end else begin
                dl[0] <= 32'hBAD0_0000;
            end
            for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
        end

        assign sram_rdata[g] = dl[LAT-1];
    end

    task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL inst%0d %s: got %h expected %h (cycle %0d)", i, name, act, exp, cyc);
    endtask

    task automatic set_port(input int i, input int p, input logic req, input logic wr,
                            input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            p0_req[i] = req; p0_wr[i] = wr; p0_wstrb[i] = st; p0_addr[i] = a; p0_wdata[i] = d;
        end else begin
            p1_req[i] = req; p1_wr[i] = wr; p1_wstrb[i] = st; p1_addr[i] = a; p1_wdata[i] = d;
        end
    endtask

    task automatic idle(input int i);
        set_port(i, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(i, 1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // One cycle: check grant/SRAM side at negedge, record expected response,
    // then advance to just after the next rising edge.
    task automatic step(input int i, input logic e0, input logic e1);
        logic        w;
        logic [3:0]  s;
        logic [31:0] a, d;
        int          p;
        exp_t        e;
        @(negedge clk);
        chk(i, "p0_addr_ok", {31'b0, p0_addr_ok[i]}, {31'b0, e0});
        chk(i, "p1_addr_ok", {31'b0, p1_addr_ok[i]}, {31'b0, e1});
        chk(i, "sram_en", {31'b0, sram_en[i]}, {31'b0, e0 | e1});
        if (e0 | e1) begin
            if (e1) begin p = 1; w = p1_wr[i]; s = p1_wstrb[i]; a = p1_addr[i]; d = p1_wdata[i]; end
            else    begin p = 0; w = p0_wr[i]; s = p0_wstrb[i]; a = p0_addr[i]; d = p0_wdata[i]; end
            chk(i, "sram_addr", sram_addr[i], a);
            chk(i, "sram_we", {28'b0, sram_we[i]}, w ? {28'b0, s} : 32'h0);
            if (w) chk(i, "sram_wdata", sram_wdata[i], d);
            e.wr   = w;
            e.data = ref_mem[i][a[7:2]];
            e.due  = cyc + lat(i);
            exp_q[i*2 + p].push_back(e);
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[i][a[7:2]][b*8 +: 8] = d[b*8 +: 8];
            end
        end else begin
            chk(i, "sram_we_idle", {28'b0, sram_we[i]}, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                logic        dok;
                logic [31:0] rd;
                exp_t        e;
                dok = (p == 0) ? p0_data_ok[i] : p1_data_ok[i];
                rd  = (p == 0) ? p0_rdata[i]   : p1_rdata[i];
                if (exp_q[i*2+p].size() > 0 && exp_q[i*2+p][0].due == cyc) begin
                    e = exp_q[i*2+p].pop_front();
                    chk(i, (p == 0) ? "p0_data_ok" : "p1_data_ok", {31'b0, dok}, 32'h1);
                    if (!e.wr && dok) chk(i, (p == 0) ? "p0_rdata" : "p1_rdata", rd, e.data);
                end else begin
                    chk(i, (p == 0) ? "p0_data_ok_idle" : "p1_data_ok_idle", {31'b0, dok}, 32'h0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 64; k++) ref_mem[i][k] = init_word(k);
            resetn[i] = 1'b0;
            idle(i);
        end
        // Requests held during reset must not be granted.
        set_port(0, 0, 1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'h1111_1111);
        set_port(1, 1, 1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
        step(0, 1'b0, 1'b0);
        resetn[0] = 1'b1;
        resetn[1] = 1'b1;
        idle(0);
        idle(1);
        step(0, 1'b0, 1'b0);

        // Single read on port 0, latency 1.
        set_port(0, 0, 1'b1, 1'b0, 4'h0, 32'h0000_001C, 32'h0);
        step(0, 1'b1, 1'b0);
        idle(0);
        step(0, 1'b0, 1'b0);

        // Round-robin: pointer starts preferring port 1, then alternates.
        begin
            int a0 = 0;
            int a1 = 0;
            for (int k = 0; k < 6; k++) begin
                logic g1;
                g1 = (k % 2 == 0);
                set_port(0, 0, 1'b1, 1'b0, 4'h0, 32'(a0 * 4), 32'h0);
                set_port(0, 1, 1'b1, 1'b0, 4'h0, 32'(32'h20 + a1 * 4), 32'h0);
                step(0, !g1, g1);
                if (g1) a1++; else a0++;
            end
        end
        idle(0);

        // Partial write on port 1, then read it back through port 0.
        set_port(0, 1, 1'b1, 1'b1, 4'b0011, 32'h0000_0040, 32'h1234_5678);
        step(0, 1'b0, 1'b1);
        idle(0);
        set_port(0, 0, 1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
        step(0, 1'b1, 1'b0);
        idle(0);
        step(0, 1'b0, 1'b0);

        // Latency 3: back-to-back reads on port 0.
        for (int k = 0; k < 3; k++) begin
            set_port(1, 0, 1'b1, 1'b0, 4'h0, 32'(k * 4), 32'h0);
            step(1, 1'b1, 1'b0);
        end
        idle(1);

        // Fixed priority: port 1 wins while both request; port 0 gets in
        // the cycle port 1 drops.
        set_port(1, 0, 1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        for (int k = 0; k < 4; k++) begin
            set_port(1, 1, 1'b1, 1'b0, 4'h0, 32'(32'h24 + k * 4), 32'h0);
            step(1, 1'b0, 1'b1);
        end
        set_port(1, 1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1, 1'b1, 1'b0);
        idle(1);

        // Write with empty strobes still returns data_ok and changes nothing.
        set_port(1, 1, 1'b1, 1'b1, 4'b0000, 32'h0000_0044, 32'hFFFF_FFFF);
        step(1, 1'b0, 1'b1);
        idle(1);
        set_port(1, 0, 1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0);
        step(1, 1'b1, 1'b0);
        idle(1);
        repeat (4) step(1, 1'b0, 1'b0);

        // Reset with two reads in flight: their responses must never appear.
        set_port(1, 0, 1'b1, 1'b0, 4'h0, 32'h0000_0048, 32'h0);
        step(1, 1'b1, 1'b0);
        idle(1);
        set_port(1, 1, 1'b1, 1'b0, 4'h0, 32'h0000_004C, 32'h0);
        step(1, 1'b0, 1'b1);
        idle(1);
        set_port(1, 0, 1'b1, 1'b0, 4'h0, 32'h0000_0050, 32'h0);
        resetn[1] = 1'b0;
        exp_q[2].delete();
        exp_q[3].delete();
        step(1, 1'b0, 1'b0);
        resetn[1] = 1'b1;
        step(1, 1'b1, 1'b0);
        idle(1);

        // Drain and confirm every expected response arrived.
        repeat (6) step(0, 1'b0, 1'b0);
        for (int q = 0; q < 4; q++) chk(q / 2, "drain", exp_q[q].size(), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
